branch_issue_queue: RTL and testbench

- Reservation station directly upstream of the branch execution unit; holds dispatched branch/jump micro-ops until both source operands are available.
- Captures operand values from the common data bus (CDB) and issues the oldest ready entry, at most one per cycle.
- Issue outputs drive the branch unit's valid/pc/imm/operand/flag/rob_tag inputs one-to-one; the branch unit has no back-pressure, so issue is a one-cycle valid pulse.
- Flushes all entries on a mispredict/recovery.

---
 rtl/branch_issue_queue_if.sv | 66 ++++++
 rtl/branch_issue_queue.sv | 165 ++++++++++++++++
 tb/tb_branch_issue_queue.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_issue_queue_if.sv
// Bundles the dispatch, CDB and issue signals of the branch issue queue.
// master = the surrounding pipeline (dispatch stage, CDB, branch unit side),
// slave  = the issue queue itself.
interface branch_issue_queue_if #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 6,
   parameter int XLEN  = 32
);
   localparam int OCC_W = $clog2(DEPTH + 1);

   // Dispatch
   logic             disp_valid_i;
   logic             disp_ready_o;
   logic [XLEN-1:0]  disp_pc_i;
   logic [XLEN-1:0]  disp_imm_i;
   logic             disp_is_branch_i;
   logic             disp_is_jump_i;
   logic             disp_pred_taken_i;
   logic [TAG_W-1:0] disp_rob_tag_i;
   logic             disp_rs1_rdy_i;
   logic [TAG_W-1:0] disp_rs1_tag_i;
   logic [XLEN-1:0]  disp_rs1_val_i;
   logic             disp_rs2_rdy_i;
   logic [TAG_W-1:0] disp_rs2_tag_i;
   logic [XLEN-1:0]  disp_rs2_val_i;

   // Common data bus and recovery
   logic             cdb_valid_i;
   logic [TAG_W-1:0] cdb_tag_i;
   logic [XLEN-1:0]  cdb_val_i;
   logic             flush_i;

   // Issue to the branch unit
   logic             issue_valid_o;
   logic [XLEN-1:0]  issue_pc_o;
   logic [XLEN-1:0]  issue_imm_o;
   logic [XLEN-1:0]  issue_rs1_val_o;
   logic [XLEN-1:0]  issue_rs2_val_o;
   logic             issue_is_branch_o;
   logic             issue_is_jump_o;
   logic             issue_pred_taken_o;
   logic [TAG_W-1:0] issue_rob_tag_o;
   logic [OCC_W-1:0] occupancy_o;

   modport master (
      output disp_valid_i, disp_pc_i, disp_imm_i, disp_is_branch_i, disp_is_jump_i,
             disp_pred_taken_i, disp_rob_tag_i,
             disp_rs1_rdy_i, disp_rs1_tag_i, disp_rs1_val_i,
             disp_rs2_rdy_i, disp_rs2_tag_i, disp_rs2_val_i,
             cdb_valid_i, cdb_tag_i, cdb_val_i, flush_i,
      input  disp_ready_o, issue_valid_o, issue_pc_o, issue_imm_o,
             issue_rs1_val_o, issue_rs2_val_o, issue_is_branch_o, issue_is_jump_o,
             issue_pred_taken_o, issue_rob_tag_o, occupancy_o
   );

   modport slave (
      input  disp_valid_i, disp_pc_i, disp_imm_i, disp_is_branch_i, disp_is_jump_i,
             disp_pred_taken_i, disp_rob_tag_i,
             disp_rs1_rdy_i, disp_rs1_tag_i, disp_rs1_val_i,
             disp_rs2_rdy_i, disp_rs2_tag_i, disp_rs2_val_i,
             cdb_valid_i, cdb_tag_i, cdb_val_i, flush_i,
      output disp_ready_o, issue_valid_o, issue_pc_o, issue_imm_o,
             issue_rs1_val_o, issue_rs2_val_o, issue_is_branch_o, issue_is_jump_o,
             issue_pred_taken_o, issue_rob_tag_o, occupancy_o
   );
endinterface

// File: rtl/branch_issue_queue.sv
// Branch reservation station. Entries are kept as a collapsing queue: slot 0
// is always the oldest, new entries append at the tail, and an issued entry
// is squeezed out by shifting the younger ones down. The slot index is thus
// the age rank, and "oldest ready" is simply the lowest ready slot.
module branch_issue_queue #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 6,
   parameter int XLEN  = 32
) (
   input logic                clk,
   input logic                rst,
   branch_issue_queue_if.slave bus
);
   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam int IDX_W = $clog2(DEPTH);

   typedef struct packed {
      logic             valid;
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  imm;
      logic             is_branch;
      logic             is_jump;
      logic             pred_taken;
      logic [TAG_W-1:0] rob_tag;
      logic             rs1_rdy;
      logic [TAG_W-1:0] rs1_tag;
      logic [XLEN-1:0]  rs1_val;
      logic             rs2_rdy;
      logic [TAG_W-1:0] rs2_tag;
      logic [XLEN-1:0]  rs2_val;
   } entry_t;

   entry_t           ent_q [DEPTH];
   entry_t           ent_d [DEPTH];
   entry_t           woke  [DEPTH];
   entry_t           new_ent;
   logic [OCC_W-1:0] occ_q;
   logic [OCC_W-1:0] occ_d;
   logic [OCC_W-1:0] tail;
   logic [DEPTH-1:0] rdy;
   logic             any_rdy;
   logic [IDX_W-1:0] sel;
   logic             disp_ready;
   logic             disp_fire;
   logic             issue_fire;

   assign disp_ready = (occ_q < OCC_W'(DEPTH));
   assign disp_fire  = bus.disp_valid_i && disp_ready && !bus.flush_i;
   assign issue_fire = any_rdy && !bus.flush_i;
   // Slot the dispatch lands in, after any same-cycle issue has collapsed the queue.
   assign tail       = occ_q - OCC_W'(issue_fire);

   assign bus.disp_ready_o  = disp_ready;
   assign bus.occupancy_o   = occ_q;
   assign bus.issue_valid_o = issue_fire;

   // Find the oldest ready entry: scan from the youngest slot so the lowest index wins.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned and infers a latch.
      rdy     = '0;
      any_rdy = 1'b0;
      sel     = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         rdy[i] = ent_q[i].valid && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy;
         if (rdy[i]) begin
            any_rdy = 1'b1;
            sel     = IDX_W'(i);
         end
      end
   end

   // Drive the branch unit from the selected entry; zero when nothing issues.
   always_comb begin
      bus.issue_pc_o         = '0;
      bus.issue_imm_o        = '0;
      bus.issue_rs1_val_o    = '0;
      bus.issue_rs2_val_o    = '0;
      bus.issue_is_branch_o  = 1'b0;
      bus.issue_is_jump_o    = 1'b0;
      bus.issue_pred_taken_o = 1'b0;
      bus.issue_rob_tag_o    = '0;
      if (issue_fire) begin
         bus.issue_pc_o         = ent_q[sel].pc;
         bus.issue_imm_o        = ent_q[sel].imm;
         bus.issue_rs1_val_o    = ent_q[sel].rs1_val;
         bus.issue_rs2_val_o    = ent_q[sel].rs2_val;
         bus.issue_is_branch_o  = ent_q[sel].is_branch;
         bus.issue_is_jump_o    = ent_q[sel].is_jump;
         bus.issue_pred_taken_o = ent_q[sel].pred_taken;
         bus.issue_rob_tag_o    = ent_q[sel].rob_tag;
      end
   end

   // Build the incoming entry, picking up a same-cycle CDB broadcast for waiting sources.
   always_comb begin
      new_ent            = '0;
      new_ent.valid      = 1'b1;
      new_ent.pc         = bus.disp_pc_i;
      new_ent.imm        = bus.disp_imm_i;
      new_ent.is_branch  = bus.disp_is_branch_i;
      new_ent.is_jump    = bus.disp_is_jump_i;
      new_ent.pred_taken = bus.disp_pred_taken_i;
      new_ent.rob_tag    = bus.disp_rob_tag_i;
      new_ent.rs1_tag    = bus.disp_rs1_tag_i;
      new_ent.rs2_tag    = bus.disp_rs2_tag_i;
      new_ent.rs1_rdy    = bus.disp_rs1_rdy_i ||
                           (bus.cdb_valid_i && (bus.cdb_tag_i == bus.disp_rs1_tag_i));
      new_ent.rs2_rdy    = bus.disp_rs2_rdy_i ||
                           (bus.cdb_valid_i && (bus.cdb_tag_i == bus.disp_rs2_tag_i));
      new_ent.rs1_val    = bus.disp_rs1_rdy_i ? bus.disp_rs1_val_i : bus.cdb_val_i;
      new_ent.rs2_val    = bus.disp_rs2_rdy_i ? bus.disp_rs2_val_i : bus.cdb_val_i;
   end

   // Next queue contents: CDB wakeup, collapse over the issued slot, append at the tail, flush.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         woke[i] = ent_q[i];
         if (bus.cdb_valid_i && ent_q[i].valid) begin
            if (!ent_q[i].rs1_rdy && (ent_q[i].rs1_tag == bus.cdb_tag_i)) begin
               woke[i].rs1_rdy = 1'b1;
               woke[i].rs1_val = bus.cdb_val_i;
            end
            if (!ent_q[i].rs2_rdy && (ent_q[i].rs2_tag == bus.cdb_tag_i)) begin
               woke[i].rs2_rdy = 1'b1;
               woke[i].rs2_val = bus.cdb_val_i;
            end
         end
      end

      for (int j = 0; j < DEPTH - 1; j++)
         ent_d[j] = (issue_fire && (j >= int'(sel))) ? woke[j + 1] : woke[j];
      ent_d[DEPTH-1] = issue_fire ? '0 : woke[DEPTH-1];

      for (int j = 0; j < DEPTH; j++)
         if (disp_fire && (OCC_W'(j) == tail))
            ent_d[j] = new_ent;

      occ_d = occ_q + OCC_W'(disp_fire) - OCC_W'(issue_fire);

      if (bus.flush_i) begin
         for (int j = 0; j < DEPTH; j++)
            ent_d[j] = '0;
         occ_d = '0;
      end
   end

   // State register for the entry array and occupancy count.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the entry array is reset in full (it is small), so the issue fields read zero out of reset.
         for (int i = 0; i < DEPTH; i++)
            ent_q[i] <= '0;
         occ_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
         ent_q <= ent_d;
         occ_q <= occ_d;
      end
   end

   // A micro-op may be a conditional branch or a jump, never both.
   a_branch_xor_jump : assert property (@(posedge clk) disable iff (rst)
      disp_fire |-> !(bus.disp_is_branch_i && bus.disp_is_jump_i));

endmodule

// File: tb/tb_branch_issue_queue.sv
// Directed bench for branch_issue_queue: single-op issue latency, CDB wakeup,
// dispatch bypass, full-queue age ordering, flush and mid-stream reset.
module tb_branch_issue_queue;
   localparam int DEPTH = 4;
   localparam int TAG_W = 6;
   localparam int XLEN  = 32;

   logic clk = 1'b0;
   logic rst;
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   branch_issue_queue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) bus ();

   branch_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      bus.disp_valid_i      = 1'b0;
      bus.disp_pc_i         = '0;
      bus.disp_imm_i        = '0;
      bus.disp_is_branch_i  = 1'b0;
      bus.disp_is_jump_i    = 1'b0;
      bus.disp_pred_taken_i = 1'b0;
      bus.disp_rob_tag_i    = '0;
      bus.disp_rs1_rdy_i    = 1'b0;
      bus.disp_rs1_tag_i    = '0;
      bus.disp_rs1_val_i    = '0;
      bus.disp_rs2_rdy_i    = 1'b0;
      bus.disp_rs2_tag_i    = '0;
      bus.disp_rs2_val_i    = '0;
      bus.cdb_valid_i       = 1'b0;
      bus.cdb_tag_i         = '0;
      bus.cdb_val_i         = '0;
      bus.flush_i           = 1'b0;
   endtask

   // One clock edge; single-cycle pulses are dropped afterwards.
   task automatic tick();
      @(posedge clk);
      #1;
      bus.disp_valid_i = 1'b0;
      bus.cdb_valid_i  = 1'b0;
      bus.flush_i      = 1'b0;
   endtask

   task automatic disp(input logic [31:0] pc, input logic [31:0] imm, input logic br,
                       input logic jmp, input logic pt, input logic [5:0] rob,
                       input logic r1rdy, input logic [5:0] r1tag, input logic [31:0] r1val,
                       input logic r2rdy, input logic [5:0] r2tag, input logic [31:0] r2val);
      bus.disp_valid_i      = 1'b1;
      bus.disp_pc_i         = pc;
      bus.disp_imm_i        = imm;
      bus.disp_is_branch_i  = br;
      bus.disp_is_jump_i    = jmp;
      bus.disp_pred_taken_i = pt;
      bus.disp_rob_tag_i    = rob;
      bus.disp_rs1_rdy_i    = r1rdy;
      bus.disp_rs1_tag_i    = r1tag;
      bus.disp_rs1_val_i    = r1val;
      bus.disp_rs2_rdy_i    = r2rdy;
      bus.disp_rs2_tag_i    = r2tag;
      bus.disp_rs2_val_i    = r2val;
   endtask

   task automatic cdb(input logic [5:0] tag, input logic [31:0] val);
      bus.cdb_valid_i = 1'b1;
      bus.cdb_tag_i   = tag;
      bus.cdb_val_i   = val;
   endtask

   task automatic chk_idle(input string tag, input int occ);
      #1;
      check_vec({tag, ".valid"}, 32'(bus.issue_valid_o), 32'd0);
      check_vec({tag, ".occ"},   32'(bus.occupancy_o),   32'(occ));
   endtask

   task automatic chk_issue(input string tag, input int rob, input logic [31:0] rs1,
                            input logic [31:0] rs2, input int occ);
      #1;
      check_vec({tag, ".valid"}, 32'(bus.issue_valid_o),   32'd1);
      check_vec({tag, ".rob"},   32'(bus.issue_rob_tag_o), 32'(rob));
      check_vec({tag, ".rs1"},   bus.issue_rs1_val_o,      rs1);
      check_vec({tag, ".rs2"},   bus.issue_rs2_val_o,      rs2);
      check_vec({tag, ".occ"},   32'(bus.occupancy_o),     32'(occ));
   endtask

   // Full-queue scenario table: rob tag, rs1 wait tag, rs2 ready/tag/value.
   logic [5:0]  f_rob   [4] = '{6'd1, 6'd2, 6'd3, 6'd4};
   logic [5:0]  f_r1tag [4] = '{6'd3, 6'd2, 6'd1, 6'd4};
   logic        f_r2rdy [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
   logic [5:0]  f_r2tag [4] = '{6'd1, 6'd2, 6'd0, 6'd0};
   logic [31:0] f_r2val [4] = '{32'h0, 32'h0, 32'hA3, 32'hA4};

   initial begin
      idle();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      // Reset state
      check_vec("rst.occ",   32'(bus.occupancy_o),   32'd0);
      check_vec("rst.ready", 32'(bus.disp_ready_o),  32'd1);
      check_vec("rst.valid", 32'(bus.issue_valid_o), 32'd0);
      check_vec("rst.pc",    bus.issue_pc_o,         32'd0);
      check_vec("rst.rob",   32'(bus.issue_rob_tag_o), 32'd0);
      rst = 1'b0;

      // Ready jump issues exactly one cycle after dispatch
      disp(32'h100, 32'h20, 1'b0, 1'b1, 1'b1, 6'd5, 1'b1, 6'd0, 32'hA, 1'b1, 6'd0, 32'hB);
      chk_idle("t1.disp", 0);
      tick();
      chk_issue("t1.iss", 5, 32'hA, 32'hB, 1);
      check_vec("t1.pc",   bus.issue_pc_o,                32'h100);
      check_vec("t1.imm",  bus.issue_imm_o,               32'h20);
      check_vec("t1.jmp",  32'(bus.issue_is_jump_o),      32'd1);
      check_vec("t1.br",   32'(bus.issue_is_branch_o),    32'd0);
      check_vec("t1.pred", 32'(bus.issue_pred_taken_o),   32'd1);
      tick();
      chk_idle("t1.after", 0);

      // Branch waiting on tag 12, woken by a CDB two cycles later
      disp(32'h200, 32'h8, 1'b1, 1'b0, 1'b0, 6'd6, 1'b0, 6'd12, 32'h0, 1'b1, 6'd0, 32'd7);
      chk_idle("t2.disp", 0);
      tick();
      chk_idle("t2.wait1", 1);
      tick();
      cdb(6'd12, 32'd9);
      chk_idle("t2.cdb", 1);
      tick();
      chk_issue("t2.iss", 6, 32'd9, 32'd7, 1);
      check_vec("t2.br", 32'(bus.issue_is_branch_o), 32'd1);
      tick();
      chk_idle("t2.after", 0);

      // Dispatch/CDB bypass on rs2
      disp(32'h300, 32'h4, 1'b1, 1'b0, 1'b0, 6'd7, 1'b1, 6'd0, 32'h11, 1'b0, 6'd3, 32'h0);
      cdb(6'd3, 32'h55);
      chk_idle("t3.disp", 0);
      tick();
      chk_issue("t3.iss", 7, 32'h11, 32'h55, 1);
      tick();
      chk_idle("t3.after", 0);

      // Fill all four entries, none ready
      for (int i = 0; i < DEPTH; i++) begin
         disp(32'h400 + 32'(i), 32'h0, 1'b1, 1'b0, 1'b0, f_rob[i],
              1'b0, f_r1tag[i], 32'h0, f_r2rdy[i], f_r2tag[i], f_r2val[i]);
         chk_idle($sformatf("t4.fill%0d", i), i);
         check_vec($sformatf("t4.fill%0d.ready", i), 32'(bus.disp_ready_o), 32'd1);
         tick();
      end
      // Wake producer tags 3,1,4,2 while a fifth op is held at dispatch
      cdb(6'd3, 32'h33);
      disp(32'h900, 32'h0, 1'b1, 1'b0, 1'b0, 6'd9, 1'b1, 6'd0, 32'h90, 1'b1, 6'd0, 32'h91);
      chk_idle("t4.w3", 4);
      check_vec("t4.w3.ready", 32'(bus.disp_ready_o), 32'd0);
      tick();
      cdb(6'd1, 32'h11);
      disp(32'h900, 32'h0, 1'b1, 1'b0, 1'b0, 6'd9, 1'b1, 6'd0, 32'h90, 1'b1, 6'd0, 32'h91);
      chk_idle("t4.w1", 4);
      check_vec("t4.w1.ready", 32'(bus.disp_ready_o), 32'd0);
      tick();
      cdb(6'd4, 32'h44);
      disp(32'h900, 32'h0, 1'b1, 1'b0, 1'b0, 6'd9, 1'b1, 6'd0, 32'h90, 1'b1, 6'd0, 32'h91);
      chk_issue("t4.iss1", 1, 32'h33, 32'h11, 4);
      check_vec("t4.iss1.ready", 32'(bus.disp_ready_o), 32'd0);
      tick();
      cdb(6'd2, 32'h22);
      disp(32'h900, 32'h0, 1'b1, 1'b0, 1'b0, 6'd9, 1'b1, 6'd0, 32'h90, 1'b1, 6'd0, 32'h91);
      chk_issue("t4.iss3", 3, 32'h11, 32'hA3, 3);
      check_vec("t4.iss3.ready", 32'(bus.disp_ready_o), 32'd1);
      tick();
      chk_issue("t4.iss2", 2, 32'h22, 32'h22, 3);
      tick();
      chk_issue("t4.iss4", 4, 32'h44, 32'hA4, 2);
      tick();
      chk_issue("t4.iss9", 9, 32'h90, 32'h91, 1);
      check_vec("t4.iss9.pc", bus.issue_pc_o, 32'h900);
      tick();
      chk_idle("t4.after", 0);

      // Flush with three valid entries, one ready, and a same-cycle dispatch
      disp(32'h500, 32'h0, 1'b1, 1'b0, 1'b0, 6'd20, 1'b0, 6'd30, 32'h0, 1'b1, 6'd0, 32'h1);
      tick();
      disp(32'h504, 32'h0, 1'b1, 1'b0, 1'b0, 6'd21, 1'b0, 6'd31, 32'h0, 1'b1, 6'd0, 32'h2);
      tick();
      disp(32'h508, 32'h0, 1'b1, 1'b0, 1'b0, 6'd22, 1'b1, 6'd0, 32'h3, 1'b1, 6'd0, 32'h4);
      tick();
      bus.flush_i = 1'b1;
      disp(32'h50C, 32'h0, 1'b1, 1'b0, 1'b0, 6'd23, 1'b1, 6'd0, 32'h5, 1'b1, 6'd0, 32'h6);
      cdb(6'd30, 32'hEE);
      chk_idle("t5.flush", 3);
      tick();
      chk_idle("t5.post", 0);
      check_vec("t5.post.ready", 32'(bus.disp_ready_o), 32'd1);
      tick();
      chk_idle("t5.lost", 0);
      cdb(6'd30, 32'h30);
      tick();
      chk_idle("t5.stale30", 0);
      cdb(6'd31, 32'h31);
      tick();
      chk_idle("t5.stale31", 0);

      // Reset mid-stream with two ready entries
      disp(32'h600, 32'h0, 1'b1, 1'b0, 1'b0, 6'd40, 1'b0, 6'd50, 32'h0, 1'b1, 6'd0, 32'h1);
      tick();
      disp(32'h604, 32'h0, 1'b1, 1'b0, 1'b0, 6'd41, 1'b0, 6'd50, 32'h0, 1'b1, 6'd0, 32'h2);
      tick();
      cdb(6'd50, 32'h5);
      tick();
      chk_issue("t6.pre", 40, 32'h5, 32'h1, 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_idle("t6.rst", 0);
      check_vec("t6.rst.ready", 32'(bus.disp_ready_o), 32'd1);
      check_vec("t6.rst.pc",    bus.issue_pc_o,        32'd0);
      disp(32'h420, 32'h0, 1'b1, 1'b0, 1'b0, 6'd42, 1'b1, 6'd0, 32'h7, 1'b1, 6'd0, 32'h8);
      chk_idle("t6.disp", 0);
      tick();
      chk_issue("t6.iss", 42, 32'h7, 32'h8, 1);
      check_vec("t6.iss.pc", bus.issue_pc_o, 32'h420);
      tick();
      chk_idle("t6.after", 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
